// File: rtl/rf_riscv_pkg.sv
// Shared constants and types for the multi-port RISC-V register file.
package rf_riscv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard: set/clear priority and per-read-port lookup.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    parameter int NWP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    set_i,
    input  logic [AW-1:0]           set_addr_i,
    input  logic [NWP-1:0]          we_i,
    input  logic [NWP-1:0][AW-1:0]  waddr_i,
    input  logic [NRP-1:0][AW-1:0]  raddr_i,
    output logic [NRP-1:0]          rbusy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears are applied first so that a same-cycle set for a new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWP; k++) begin
            if (we_i[k] && (waddr_i[k] != '0)) begin
                busy_d[waddr_i[k]] = 1'b0;
            end
        end
        if (set_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_lookup
            assign rbusy_o[gi] = (raddr_i[gi] == '0) ? 1'b0 : busy_q[raddr_i[gi]];
        end
    endgenerate

endmodule

// File: rtl/rf_riscv_mp.sv
// Multi-port register file with x0 hardwired to zero and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rf_riscv_mp
    import rf_riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP   = 2,
    parameter int NWP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NWP-1:0]           we_i,
    input  logic [NWP-1:0][AW-1:0]   waddr_i,
    input  logic [NWP-1:0][XLEN-1:0] wdata_i,
    input  logic [NRP-1:0][AW-1:0]   raddr_i,
    output logic [NRP-1:0][XLEN-1:0] rdata_o,
    input  logic                     busy_set_i,
    input  logic [AW-1:0]            busy_addr_i,
    output logic [NRP-1:0]           rbusy_o
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NRP-1:0]  sb_rbusy;

    // Ascending port order lets the highest-indexed port win an address collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int k = 0; k < NWP; k++) begin
            if (we_i[k] && (waddr_i[k] != '0)) begin
                mem_d[waddr_i[k]] = wdata_i[k];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRP   (NRP),
        .NWP   (NWP)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (busy_set_i),
        .set_addr_i (busy_addr_i),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .raddr_i    (raddr_i),
        .rbusy_o    (sb_rbusy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_read
            logic [XLEN-1:0] stored_data;
            assign stored_data = (raddr_i[gi] == '0) ? '0 : mem_q[raddr_i[gi]];
`ifdef RF_BYPASS_EN
            logic            byp_hit;
            logic [XLEN-1:0] byp_data;

            always_comb begin
                byp_hit  = 1'b0;
                byp_data = '0;
                for (int k = 0; k < NWP; k++) begin
                    if (we_i[k] && (waddr_i[k] != '0) && (waddr_i[k] == raddr_i[gi])) begin
                        byp_hit  = 1'b1;
                        byp_data = wdata_i[k];
                    end
                end
            end

            // A forwarded value is no longer pending unless a new producer claims it now.
            assign rdata_o[gi] = byp_hit ? byp_data : stored_data;
            assign rbusy_o[gi] = byp_hit ? (busy_set_i && (busy_addr_i == raddr_i[gi]))
                                         : sb_rbusy[gi];
`else
            assign rdata_o[gi] = stored_data;
            assign rbusy_o[gi] = sb_rbusy[gi];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Self-checking bench for rf_riscv_mp: directed vector table, reset/bypass sequences, random run.
module tb_rf_riscv_mp;
    import rf_riscv_pkg::*;

    localparam int XL  = 64;
    localparam int NR  = 32;
    localparam int NRP = 4;
    localparam int NWP = 2;

    logic                   clk;
    logic                   rst_ni;
    logic [NWP-1:0]         we;
    logic [NWP-1:0][4:0]    waddr;
    logic [NWP-1:0][XL-1:0] wdata;
    logic [NRP-1:0][4:0]    raddr;
    logic [NRP-1:0][XL-1:0] rdata;
    logic                   bset;
    reg_addr_t              baddr;
    logic [NRP-1:0]         rbusy;

    rf_riscv_mp #(.XLEN(XL), .NREGS(NR), .NRP(NRP), .NWP(NWP)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .busy_set_i (bset),
        .busy_addr_i(baddr),
        .rbusy_o    (rbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [XL-1:0] m_reg  [NR];
    logic          m_busy [NR];

    typedef struct {
        int            port;
        logic [XL-1:0] rd;
        logic          rb;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [1:0]    we;
        logic [4:0]    wa0;
        logic [XL-1:0] wd0;
        logic [4:0]    wa1;
        logic [XL-1:0] wd1;
        logic          bs;
        logic [4:0]    ba;
        logic [4:0]    ra;
        logic [XL-1:0] erd;
        logic          erb;
    } vec_t;
    vec_t tbl [14];

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic logic wr_hit(input logic [4:0] a);
        logic h = 1'b0;
        for (int k = 0; k < NWP; k++) if (we[k] && waddr[k] != 0 && waddr[k] == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [XL-1:0] model_rd(input logic [4:0] a);
        logic [XL-1:0] v;
        if (a == 0) return '0;
        v = m_reg[a];
`ifdef RF_BYPASS_EN
        for (int k = 0; k < NWP; k++) if (we[k] && waddr[k] == a) v = wdata[k];
`endif
        return v;
    endfunction

    function automatic logic model_rb(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wr_hit(a)) return bset && (baddr == a);
`endif
        return m_busy[a];
    endfunction

    task automatic model_update();
        if (!rst_ni) return;
        for (int k = 0; k < NWP; k++) begin
            if (we[k] && waddr[k] != 0) begin
                m_reg[waddr[k]]  = wdata[k];
                m_busy[waddr[k]] = 1'b0;
            end
        end
        if (bset && baddr != 0) m_busy[baddr] = 1'b1;
    endtask

    task automatic set_in(input logic [1:0] w, input logic [4:0] a0, input logic [XL-1:0] d0,
                          input logic [4:0] a1, input logic [XL-1:0] d1,
                          input logic bs, input logic [4:0] ba,
                          input logic [4:0] r0, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] r3);
        we = w; waddr[0] = a0; wdata[0] = d0; waddr[1] = a1; wdata[1] = d1;
        bset = bs; baddr = ba;
        raddr[0] = r0; raddr[1] = r1; raddr[2] = r2; raddr[3] = r3;
    endtask

    task automatic push_exp(input int p, input logic [XL-1:0] rd, input logic rb);
        exp_t e;
        e.port = p; e.rd = rd; e.rb = rb;
        sb_q.push_back(e);
    endtask

    task automatic push_model();
        for (int p = 0; p < NRP; p++) push_exp(p, model_rd(raddr[p]), model_rb(raddr[p]));
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (rdata[e.port] !== e.rd) begin
                errors++;
                $display("FAIL %s rdata[%0d] (x%0d): got %h expected %h",
                         tag, e.port, raddr[e.port], rdata[e.port], e.rd);
            end
            checks++;
            if (rbusy[e.port] !== e.rb) begin
                errors++;
                $display("FAIL %s rbusy[%0d] (x%0d): got %b expected %b",
                         tag, e.port, raddr[e.port], rbusy[e.port], e.rb);
            end
        end
    endtask

    // Inputs are already driven just after a falling edge; compare, then let the edge commit.
    task automatic cycle_check(input string tag, input bit use_exp,
                               input logic [XL-1:0] e_rd, input logic e_rb);
        if (use_exp) begin
            for (int p = 0; p < NRP; p++) push_exp(p, e_rd, e_rb);
        end else begin
            push_model();
        end
        #1;
        drain(tag);
        @(posedge clk);
        model_update();
    endtask

    initial begin
        tbl[0]  = '{2'b01, 5'd1, 64'h100, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 64'h0, 1'b0};
        tbl[1]  = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd1, 64'h100, 1'b0};
        tbl[2]  = '{2'b11, 5'd7, 64'h11111111, 5'd7, 64'h22222222, 1'b0, 5'd0, 5'd1, 64'h100, 1'b0};
        tbl[3]  = '{2'b10, 5'd0, 64'h0, 5'd2, 64'hFEDC_BA98_7654_3210, 1'b0, 5'd0, 5'd7, 64'h22222222, 1'b0};
        tbl[4]  = '{2'b01, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 64'h22222222, 1'b0};
        tbl[5]  = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 64'h0, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd2, 64'hFEDC_BA98_7654_3210, 1'b0};
        tbl[7]  = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 64'h0, 1'b1};
        tbl[8]  = '{2'b10, 5'd0, 64'h0, 5'd9, 64'h99, 1'b0, 5'd0, 5'd1, 64'h100, 1'b0};
        tbl[9]  = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 64'h99, 1'b0};
        tbl[10] = '{2'b01, 5'd9, 64'h98, 5'd0, 64'h0, 1'b1, 5'd9, 5'd7, 64'h22222222, 1'b0};
        tbl[11] = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 64'h98, 1'b1};
        tbl[12] = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 64'h0, 1'b0};
        tbl[13] = '{2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 64'h0, 1'b0};

        model_clear();
        rst_ni = 1'b0;
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Writes and busy_set held during reset must not take effect.
        @(negedge clk);
        set_in(2'b11, 5'd4, 64'h44, 5'd4, 64'h45, 1'b1, 5'd4, 5'd4, 5'd4, 5'd0, 5'd4);
        cycle_check("reset_hold", 1'b1, 64'h0, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd4, 5'd4, 5'd4, 5'd4);
        cycle_check("reset_state", 1'b1, 64'h0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_in(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                   tbl[i].bs, tbl[i].ba, tbl[i].ra, tbl[i].ra, tbl[i].ra, tbl[i].ra);
            cycle_check($sformatf("vec%0d", i), 1'b1, tbl[i].erd, tbl[i].erb);
            $display("vec%0d: raddr=x%0d rdata0=%h rbusy0=%b", i, tbl[i].ra, rdata[0], rbusy[0]);
        end

        // Asynchronous reset in mid-cycle.
        @(negedge clk);
        set_in(2'b01, 5'd5, 64'hDEADBEEF, 0, 0, 1'b1, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle_check("rst_pre", 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd6, 5'd5, 5'd6);
        #1;
        push_exp(0, 64'hDEADBEEF, 1'b0); push_exp(1, 64'h0, 1'b1);
        push_exp(2, 64'hDEADBEEF, 1'b0); push_exp(3, 64'h0, 1'b1);
        drain("rst_before");
        #2 rst_ni = 1'b0;
        #1;
        for (int p = 0; p < NRP; p++) push_exp(p, 64'h0, 1'b0);
        drain("rst_async");
        $display("rst_async: rdata0=%h rbusy1=%b", rdata[0], rbusy[1]);
        model_clear();
        set_in(2'b01, 5'd5, 64'h55, 0, 0, 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        for (int p = 0; p < NRP; p++) push_exp(p, 64'h0, 1'b0);
        drain("rst_release");
        @(posedge clk);
        model_update();
        @(negedge clk);
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd5, 5'd5, 5'd5);
        cycle_check("rst_first_write", 1'b1, 64'h55, 1'b1);

        // Same-cycle write and read of x3.
        @(negedge clk);
        set_in(2'b01, 5'd3, 64'hA5A5A5A5, 0, 0, 1'b0, 0, 5'd3, 5'd3, 5'd3, 5'd3);
`ifdef RF_BYPASS_EN
        cycle_check("bypass", 1'b1, 64'hA5A5A5A5, 1'b0);
`else
        cycle_check("bypass", 1'b1, 64'h0, 1'b0);
`endif
        @(negedge clk);
        set_in(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd3, 5'd3, 5'd3);
        cycle_check("bypass_after", 1'b1, 64'hA5A5A5A5, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            logic [4:0] ra [NRP];
            logic [4:0] wa [NWP];
            logic [4:0] ba;
            bit narrow = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < NWP; k++) wa[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int p = 0; p < NRP; p++) ra[p] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ba = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            @(negedge clk);
            set_in(2'($urandom_range(0, 3)), wa[0], {$urandom, $urandom}, wa[1], {$urandom, $urandom},
                   1'($urandom_range(0, 1)), ba, ra[0], ra[1], ra[2], ra[3]);
            cycle_check("random", 1'b0, 64'h0, 1'b0);
            if (i % 1000 == 0)
                $display("random%0d: raddr0=x%0d rdata0=%h rbusy=%b", i, raddr[0], rdata[0], rbusy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
